// File: rtl/i2c_slave_rx_if.sv
// Pad-side and byte-stream signals of the write-only I2C slave receiver.
// The slave modport is the receiver's view; master is the bus/consumer side.
interface i2c_slave_rx_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       start_det;
  logic       stop_det;
  logic       busy;
  logic       overrun;

  modport slave (
    input  scl_i, sda_i, rx_ready,
    output sda_oe, rx_data, rx_valid, start_det, stop_det, busy, overrun
  );

  modport master (
    output scl_i, sda_i, rx_ready,
    input  sda_oe, rx_data, rx_valid, start_det, stop_det, busy, overrun
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver, oversampling SCL/SDA on the local clock.
// Optional glitch filter on the resynchronised lines: define I2C_GLITCH_FILTER_EN.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input logic           clk,
  input logic           reset,
  i2c_slave_rx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, DATA_NACK, WAIT_STOP
  } state_t;

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("i2c_slave_rx: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  // Stage p0: resynchronise the pad lines; flops idle high like the bus
  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], bus.sda_i};
    end
  end

  // Stage p1: current line value seen by the protocol logic
  logic scl_p1, sda_p1;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  logic [CNT_W-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p1  <= 1'b1;
      sda_p1  <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync_p0[SYNC_STAGES-1] == scl_p1) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_LAST) begin
        scl_p1  <= scl_sync_p0[SYNC_STAGES-1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync_p0[SYNC_STAGES-1] == sda_p1) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_LAST) begin
        sda_p1  <= sda_sync_p0[SYNC_STAGES-1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_p1 = scl_sync_p0[SYNC_STAGES-1];
  assign sda_p1 = sda_sync_p0[SYNC_STAGES-1];
`endif

  // Stage p2: previous sample for edge and START/STOP detection
  logic scl_p2, sda_p2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_p2 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p2 <= scl_p1;
      sda_p2 <= sda_p1;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_rise   = scl_p1 & ~scl_p2;
  assign scl_fall   = ~scl_p1 & scl_p2;
  assign start_cond = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_cond  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, shift_in;
  logic       sda_oe_q, sda_oe_n;
  logic [7:0] rx_data_q, rx_data_n;
  logic       rx_valid_q, rx_valid_n;
  logic       overrun_q, overrun_n;
  logic       start_det_q, stop_det_q;

  assign shift_in = {shreg[6:0], sda_p1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      sda_oe_q    <= sda_oe_n;
      rx_data_q   <= rx_data_n;
      rx_valid_q  <= rx_valid_n;
      overrun_q   <= overrun_n;
      start_det_q <= start_cond;
      stop_det_q  <= stop_cond;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  // ACK states use bit_cnt as a phase flag: 0 = before first SCL fall, 1 = driving
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    overrun_n  = overrun_q;
    if (start_cond) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      overrun_n = 1'b0;
    end else if (stop_cond) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ADDR, DATA: begin
          if (scl_rise) begin
            shreg_n = shift_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = '0;
              if (state == ADDR) begin
                state_n = (shift_in[7:1] == SLAVE_ADDR && !shift_in[0]) ? ADDR_ACK : WAIT_STOP;
              end else if (bus.rx_ready) begin
                rx_data_n  = shift_in;
                rx_valid_n = 1'b1;
                state_n    = DATA_ACK;
              end else begin
                overrun_n = 1'b1;
                state_n   = DATA_NACK;
              end
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n  = 1'b1;
              bit_cnt_n = 4'd1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = DATA;
            end
          end
        end
        DATA_NACK: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              bit_cnt_n = 4'd1;
            end else begin
              bit_cnt_n = '0;
              state_n   = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.start_det = start_det_q;
  assign bus.stop_det  = stop_det_q;
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Randomised bench for i2c_slave_rx: a bit-banged I2C master plus a
// transaction-level model of which bytes must be ACKed, delivered or dropped.
`timescale 1ns/1ps
module tb_i2c_slave_rx;

`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int Q    = 10;
`else
  localparam bit FILT = 1'b0;
  localparam int Q    = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sda_drv = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int n_start = 0;
  int n_stop = 0;
  bit oe_seen = 1'b0;
  bit [7:0] got_q[$];

  bit [7:0] rdata [4];
  bit       rrdy  [4];

  i2c_slave_rx_if bus ();

  // Open-drain bus: the slave's pull-down wins over the master's release
  assign bus.sda_i = sda_drv & ~bus.sda_oe;

  i2c_slave_rx #(
    .SLAVE_ADDR (7'h42),
    .SYNC_STAGES(2),
    .FILTER_LEN (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_valid)  got_q.push_back(bus.rx_data);
      if (bus.start_det) n_start++;
      if (bus.stop_det)  n_stop++;
      if (bus.sda_oe)    oe_seen = 1'b1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(Q);
    bus.scl_i = 1'b1;
    wait_clk(Q);
    sda_drv = 1'b0;
    wait_clk(Q);
    bus.scl_i = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(Q);
    bus.scl_i = 1'b1;
    wait_clk(Q);
    sda_drv = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_bit(input bit b);
    sda_drv = b;
    wait_clk(Q);
    bus.scl_i = 1'b1;
    wait_clk(Q);
    bus.scl_i = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_ack(output bit ack);
    sda_drv = 1'b1;
    wait_clk(Q);
    bus.scl_i = 1'b1;
    wait_clk(Q / 2);
    ack = bus.sda_oe;
    wait_clk(Q - Q / 2);
    bus.scl_i = 1'b0;
    wait_clk(Q);
  endtask

  task automatic send_byte(input bit [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    read_ack(ack);
  endtask

  // Model: the address is ACKed only for a write to 0x42; each data byte is
  // ACKed and delivered while rx_ready is high, the first refused byte sets
  // overrun and everything after it is ignored until STOP.
  task automatic run_xfer(input bit [6:0] addr, input bit rw, input int nb,
                          input bit [7:0] data [4], input bit rdy [4]);
    bit       ack;
    bit       live;
    bit       exp_ovr;
    bit       any_ack;
    bit [7:0] exp_q[$];
    int       s0;
    int       p0;
    got_q.delete();
    oe_seen = 1'b0;
    s0 = n_start;
    p0 = n_stop;
    live = (addr == 7'h42) && !rw;
    any_ack = live;
    exp_ovr = 1'b0;
    i2c_start();
    check_val("busy_after_start", bus.busy, 1);
    send_byte({addr, rw}, ack);
    check_val("addr_ack", ack, live);
    for (int i = 0; i < nb; i++) begin
      bus.rx_ready = rdy[i];
      send_byte(data[i], ack);
      check_val("data_ack", ack, live && rdy[i]);
      if (live && rdy[i]) exp_q.push_back(data[i]);
      else if (live) begin
        exp_ovr = 1'b1;
        live = 1'b0;
      end
    end
    check_val("busy_before_stop", bus.busy, 1);
    i2c_stop();
    check_val("busy_after_stop", bus.busy, 0);
    check_val("overrun", bus.overrun, exp_ovr);
    check_val("start_cnt", n_start - s0, 1);
    check_val("stop_cnt", n_stop - p0, 1);
    check_val("rx_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_val("rx_byte", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
    if (exp_q.size() > 0) check_val("rx_data", bus.rx_data, exp_q[exp_q.size() - 1]);
    if (!any_ack) check_val("no_oe", oe_seen, 0);
    bus.rx_ready = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit       ack;
    bit [7:0] abyte;
    int       s0;
    int       p0;

    bus.scl_i    = 1'b1;
    bus.rx_ready = 1'b1;
    sda_drv      = 1'b1;
    wait_clk(3);
    check_val("rst_sda_oe", bus.sda_oe, 0);
    check_val("rst_rx_data", bus.rx_data, 0);
    check_val("rst_rx_valid", bus.rx_valid, 0);
    check_val("rst_start_det", bus.start_det, 0);
    check_val("rst_stop_det", bus.stop_det, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    wait_clk(4);

    // Directed cases
    rdata[0] = 8'hA5; rrdy[0] = 1'b1;
    run_xfer(7'h42, 1'b0, 1, rdata, rrdy);
    rdata[0] = 8'h11; rrdy[0] = 1'b1;
    run_xfer(7'h43, 1'b0, 1, rdata, rrdy);
    run_xfer(7'h42, 1'b1, 0, rdata, rrdy);
    rdata[0] = 8'h3C; rrdy[0] = 1'b0;
    run_xfer(7'h42, 1'b0, 1, rdata, rrdy);
    i2c_start();
    check_val("overrun_cleared", bus.overrun, 0);
    i2c_stop();

    // Partial byte cut off by a repeated START
    got_q.delete();
    s0 = n_start;
    i2c_start();
    send_byte(8'h84, ack);
    check_val("rs_addr_ack1", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_start();
    send_byte(8'h84, ack);
    check_val("rs_addr_ack2", ack, 1);
    send_byte(8'h7E, ack);
    check_val("rs_data_ack", ack, 1);
    i2c_stop();
    check_val("rs_rx_count", got_q.size(), 1);
    check_val("rs_rx_byte", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 8'h7E);
    check_val("rs_start_cnt", n_start - s0, 2);

    // Two-cycle SDA low glitch while SCL idles high
    s0 = n_start;
    p0 = n_stop;
    wait_clk(4);
    sda_drv = 1'b0;
    wait_clk(2);
    sda_drv = 1'b1;
    wait_clk(20);
    check_val("glitch_start", n_start - s0, FILT ? 0 : 1);
    check_val("glitch_stop", n_stop - p0, FILT ? 0 : 1);
    check_val("glitch_busy", bus.busy, 0);

    // Reset while the address ACK is being driven
    i2c_start();
    abyte = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(abyte[i]);
    sda_drv = 1'b1;
    wait_clk(Q / 2);
    check_val("ack_before_reset", bus.sda_oe, 1);
    #3;
    reset = 1'b1;
    #1;
    check_val("reset_sda_oe", bus.sda_oe, 0);
    check_val("reset_busy", bus.busy, 0);
    bus.scl_i = 1'b1;
    sda_drv = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2 * Q);

    // Randomised transactions
    for (int t = 0; t < 25; t++) begin
      bit [6:0] addr;
      bit       rw;
      int       nb;
      int       sel;
      sel = $urandom_range(0, 3);
      if (sel < 2)       addr = 7'h42;
      else if (sel == 2) addr = 7'h43;
      else               addr = 7'($urandom_range(0, 127));
      rw = ($urandom_range(0, 3) == 0);
      nb = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        rdata[i] = 8'($urandom);
        rrdy[i]  = ($urandom_range(0, 4) != 0);
      end
      run_xfer(addr, rw, nb, rdata, rrdy);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Write-only I2C slave receiver. Consumes the buffered bus clock and data and runs synchronously on the local clock `clk`.
- Resynchronises SCL/SDA and detects START/STOP.
- Matches the 7-bit address and ACKs matching write transactions.
- Delivers each received data byte on a one-cycle valid strobe.
- Drives only an open-drain pull-down enable, for the pad stage downstream.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave responds to.
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (min 2).
- FILTER_LEN, 4, stable-sample count for the glitch filter (only used with I2C_GLITCH_FILTER_EN).

Ports:
- clk, input, 1, local sampling clock; must be at least 8x SCL frequency.
- reset, input, 1, asynchronous active-high reset.
- scl_i, input, 1, raw SCL from pad.
- sda_i, input, 1, raw SDA from pad.
- sda_oe, output, 1, 1 = pull SDA low (ACK); 0 = release.
- rx_ready, input, 1, consumer can accept a byte.
- rx_data, output, 8, last received data byte.
- rx_valid, output, 1, one-cycle strobe when rx_data is updated.
- start_det, output, 1, one-cycle pulse on START or repeated START.
- stop_det, output, 1, one-cycle pulse on STOP.
- busy, output, 1, high from START to STOP.
- overrun, output, 1, sticky; set when a byte is dropped because rx_ready=0; cleared by START.

Behaviour:
- Clock clk; reset reset, asynchronous, active-high.
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, start_det=0, stop_det=0, busy=0, overrun=0, FSM=IDLE, bit counter=0. Synchroniser flops reset to 1 (idle bus).
- Synchronisation and edge detection:
  - SYNC_STAGES flops feed a previous-value register; all edges are detected on synchronised values.
  - Latency from a pad change to the internal edge is SYNC_STAGES+1 clk cycles.
- START: SDA 1->0 while SCL is high in both the previous and current sample.
- STOP: SDA 0->1 under the same SCL condition.
- If SCL and SDA change in the same cycle, no START/STOP is reported and only the SCL edge is processed.
- Bit sampling: on an SCL rising edge, shift in the current synchronised SDA, MSB first.
- FSM states and transitions:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits (7 address + R/W). After the 8th rising edge:
    - address==SLAVE_ADDR and R/W=0 -> ADDR_ACK.
    - Otherwise -> WAIT_STOP, with no ACK.
  - ADDR_ACK: on the next SCL falling edge, sda_oe=1. On the following falling edge (end of 9th clock), sda_oe=0 and -> DATA.
  - DATA: shift 8 bits. After the 8th rising edge:
    - If rx_ready=1: rx_data <= shifted byte and rx_valid=1 for exactly one cycle, then -> DATA_ACK.
    - If rx_ready=0: drop the byte, set overrun, -> DATA_NACK.
  - DATA_ACK: ACK timing as ADDR_ACK, then -> DATA.
  - DATA_NACK: sda_oe stays 0 for the 9th clock, then -> WAIT_STOP.
  - WAIT_STOP: ignore SCL until START or STOP.
- START in any state (repeated START):
  - Bit counter cleared, sda_oe forced 0, -> ADDR.
  - start_det pulses and overrun is cleared.
- STOP in any state: sda_oe=0 and -> IDLE; stop_det pulses.
- STOP or START arriving mid-byte discards the partial byte; rx_valid never fires for it.
- busy=1 in every state except IDLE.
- The bit counter is 4 bits and wraps to 0 at each byte/ACK boundary; it never exceeds 8.
- sda_oe is registered, with no combinational path from any input.
- Reset asserted mid-transfer returns to the reset values immediately; no ACK is held.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- When defined: each synchronised line passes through a filter. The filtered value changes only after the raw synchronised value has differed from it for FILTER_LEN consecutive clk cycles. Pulses shorter than FILTER_LEN cycles are suppressed, and edge latency increases by FILTER_LEN cycles.
- When undefined: the filter is absent and the synchronised values are used directly.

Test Plan:
- Write to 0x42 with data 0xA5, rx_ready=1, then STOP -> start_det pulse; ACK low on 9th clock after address and after data; rx_data=0xA5 with one rx_valid pulse; stop_det pulse; busy=0.
- Address 0x43 write, then 0x11 -> sda_oe never asserted; rx_valid never fires; busy=1 until STOP.
- Address 0x42 with R/W=1 -> no ACK; FSM in WAIT_STOP; STOP returns to IDLE.
- Write 0x42, 0x3C with rx_ready=0 -> no ACK on the data byte; overrun=1; no rx_valid; next START clears overrun.
- Write 0x42, send 4 bits of data, then repeated START + 0x42 + 0x7E -> partial byte discarded; single rx_valid with rx_data=0x7E; start_det pulses twice.
- With I2C_GLITCH_FILTER_EN and FILTER_LEN=4: 2-cycle low glitch on SDA while SCL high -> no start_det. Without the macro, the same stimulus produces a start_det pulse.
